comp_triad_packer: RTL and testbench

COMP_TRIAD_PACKER -- requirements
Module: comp_triad_packer

---
 rtl/comp_pkt_pkg.sv | 36 +++
 rtl/comp_triad_packer_if.sv | 27 ++
 rtl/comp_triad_packer.sv | 158 +++++++++++++++
 tb/tb_comp_triad_packer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkt_pkg.sv
// Shared definitions for the comparator triad packer: FSM encoding, packet tags,
// default packet geometry and the 48-to-16 slice selector.
package comp_pkt_pkg;

  localparam int unsigned FifoWidth = 48;
  localparam int unsigned TxWidth   = 16;

  localparam int unsigned DefNPre        = 4;
  localparam int unsigned DefNTriadWords = 9;
  localparam int unsigned DefTimeout     = 255;

  localparam logic [7:0] HdrTag = 8'hCF;
  localparam logic [7:0] TrlTag = 8'hCE;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StHdr,
    StSeq,
    StFetch,
    StLoad,
    StSend,
    StTrl
  } pkt_state_e;

  // Slice 0 is the most significant 16 bits of the FIFO word.
  function automatic logic [TxWidth-1:0] slice_of(input logic [FifoWidth-1:0] word,
                                                  input logic [1:0] idx);
    case (idx)
      2'd0:    return word[47:32];
      2'd1:    return word[31:16];
      default: return word[15:0];
    endcase
  endfunction

endpackage

// File: rtl/comp_triad_packer_if.sv
// FIFO-side and transmitter-side signals of the triad packer, plus its status outputs.
interface comp_triad_packer_if;
  import comp_pkt_pkg::*;

  logic                 compfifo_dav;
  logic [FifoWidth-1:0] compfifo_dout;
  logic                 en_fiforead;
  logic                 tx_ready;
  logic [TxWidth-1:0]   tx_dat;
  logic                 tx_valid;
  logic                 tx_sof;
  logic                 tx_eof;
  logic                 busy;
  logic [15:0]          pkt_count;
  logic [7:0]           underrun_count;

  modport master (
    input  compfifo_dav, compfifo_dout, tx_ready,
    output en_fiforead, tx_dat, tx_valid, tx_sof, tx_eof, busy, pkt_count, underrun_count
  );

  modport slave (
    output compfifo_dav, compfifo_dout, tx_ready,
    input  en_fiforead, tx_dat, tx_valid, tx_sof, tx_eof, busy, pkt_count, underrun_count
  );

endinterface

// File: rtl/comp_triad_packer.sv
// Packs 48-bit comparator FIFO words into framed 16-bit GbE packets
// (preamble, header, sequence, data triads, trailer) with FIFO-starvation timeout.
module comp_triad_packer
  import comp_pkt_pkg::*;
#(
  parameter int unsigned FIBER_ID      = 0,
  parameter int unsigned N_PRE         = DefNPre,
  parameter int unsigned N_TRIAD_WORDS = DefNTriadWords,
  parameter int unsigned TIMEOUT       = DefTimeout
) (
  input logic                 fabric_clk,
  input logic                 reset,
  comp_triad_packer_if.master bus
);

  pkt_state_e           state_q, state_d;
  logic [7:0]           pre_cnt_q, pre_cnt_d;
  logic [7:0]           word_cnt_q, word_cnt_d;
  logic [1:0]           slice_q, slice_d;
  logic [7:0]           timer_q, timer_d;
  logic [FifoWidth-1:0] stage_q, stage_d;
  logic                 uflag_q, uflag_d;
  logic [15:0]          pkt_count_q, pkt_count_d;
  logic [7:0]           underrun_count_q, underrun_count_d;

  logic               tx_valid, tx_sof, tx_eof, en_fiforead;
  logic [TxWidth-1:0] tx_dat;

  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      state_q          <= StIdle;
      pre_cnt_q        <= '0;
      word_cnt_q       <= '0;
      slice_q          <= '0;
      timer_q          <= '0;
      stage_q          <= '0;
      uflag_q          <= 1'b0;
      pkt_count_q      <= '0;
      underrun_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pre_cnt_q        <= pre_cnt_d;
      word_cnt_q       <= word_cnt_d;
      slice_q          <= slice_d;
      timer_q          <= timer_d;
      stage_q          <= stage_d;
      uflag_q          <= uflag_d;
      pkt_count_q      <= pkt_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pre_cnt_d        = pre_cnt_q;
    word_cnt_d       = word_cnt_q;
    slice_d          = slice_q;
    timer_d          = timer_q;
    stage_d          = stage_q;
    uflag_d          = uflag_q;
    pkt_count_d      = pkt_count_q;
    underrun_count_d = underrun_count_q;
    tx_valid         = 1'b0;
    tx_sof           = 1'b0;
    tx_eof           = 1'b0;
    tx_dat           = '0;
    en_fiforead      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.compfifo_dav) begin
          state_d   = StPre;
          pre_cnt_d = '0;
        end
      end
      StPre: begin
        tx_valid = 1'b1;
        tx_sof   = (pre_cnt_q == '0);
        if (bus.tx_ready) begin
          if (pre_cnt_q == 8'(N_PRE - 1)) state_d = StHdr;
          else pre_cnt_d = pre_cnt_q + 8'd1;
        end
      end
      StHdr: begin
        tx_valid = 1'b1;
        tx_dat   = {HdrTag, 8'(FIBER_ID)};
        if (bus.tx_ready) state_d = StSeq;
      end
      StSeq: begin
        tx_valid = 1'b1;
        tx_dat   = pkt_count_q;
        if (bus.tx_ready) begin
          state_d    = StFetch;
          word_cnt_d = '0;
          timer_d    = '0;
        end
      end
      StFetch: begin
        // Once underrun, the rest of the packet is zero-filled without touching the FIFO.
        if (uflag_q) begin
          state_d = StLoad;
        end else if (bus.compfifo_dav) begin
          en_fiforead = 1'b1;
          state_d     = StLoad;
        end else if (timer_q == 8'(TIMEOUT)) begin
          uflag_d = 1'b1;
          state_d = StLoad;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StLoad: begin
        stage_d    = uflag_q ? '0 : bus.compfifo_dout;
        slice_d    = '0;
        word_cnt_d = word_cnt_q + 8'd1;
        state_d    = StSend;
      end
      StSend: begin
        tx_valid = 1'b1;
        tx_dat   = slice_of(stage_q, slice_q);
        if (bus.tx_ready) begin
          if (slice_q == 2'd2) begin
            if (word_cnt_q < 8'(N_TRIAD_WORDS)) begin
              state_d = StFetch;
              timer_d = '0;
            end else begin
              state_d = StTrl;
            end
          end else begin
            slice_d = slice_q + 2'd1;
          end
        end
      end
      StTrl: begin
        tx_valid = 1'b1;
        tx_eof   = 1'b1;
        tx_dat   = {TrlTag, 7'b0, uflag_q};
        if (bus.tx_ready) begin
          pkt_count_d = pkt_count_q + 16'd1;
          if (uflag_q && underrun_count_q != 8'hFF) underrun_count_d = underrun_count_q + 8'd1;
          uflag_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.tx_valid       = tx_valid;
  assign bus.tx_sof         = tx_sof;
  assign bus.tx_eof         = tx_eof;
  assign bus.tx_dat         = tx_dat;
  assign bus.en_fiforead    = en_fiforead;
  assign bus.busy           = (state_q != StIdle);
  assign bus.pkt_count      = pkt_count_q;
  assign bus.underrun_count = underrun_count_q;

endmodule

// File: tb/tb_comp_triad_packer.sv
// Randomised self-checking bench: FIFO model plus a packet-level reference model
// built from the framing rules, compared against every transferred word.
module tb_comp_triad_packer;

  localparam int unsigned FIBER   = 3;
  localparam int unsigned NPRE    = 4;
  localparam int unsigned NTW     = 9;
  localparam int unsigned TMO     = 255;
  localparam int          PKT_LEN = NPRE + 3 + 3 * NTW;

  logic fabric_clk = 1'b0;
  logic reset      = 1'b1;
  always #5 fabric_clk = ~fabric_clk;

  comp_triad_packer_if bus ();

  comp_triad_packer #(
    .FIBER_ID      (FIBER),
    .N_PRE         (NPRE),
    .N_TRIAD_WORDS (NTW),
    .TIMEOUT       (TMO)
  ) dut (
    .fabric_clk (fabric_clk),
    .reset      (reset),
    .bus        (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [47:0] fifo_q[$];
  logic [47:0] model_words[$];
  logic        pop_pending = 1'b0;
  int          pops = 0;
  int          stall_err = 0;
  int          pop_empty_err = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;
  logic        prev_sof = 1'b0, prev_eof = 1'b0;

  logic [15:0] cap_dat[$];
  logic        cap_sof[$];
  logic        cap_eof[$];
  int          cap_cyc[$];
  int          n_eof = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_pkt = '0;
  logic [7:0]  exp_under = '0;

  // One clock: FIFO/ready update after the falling edge, outputs sampled 1 unit later.
  task automatic step(input bit rdy);
    @(negedge fabric_clk);
    if (pop_pending && fifo_q.size() != 0) bus.compfifo_dout = fifo_q.pop_front();
    pop_pending      = 1'b0;
    bus.compfifo_dav = (fifo_q.size() != 0);
    bus.tx_ready     = rdy;
    #1;
    cyc++;
    if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_dat !== prev_dat ||
                       bus.tx_sof !== prev_sof || bus.tx_eof !== prev_eof)) stall_err++;
    prev_stall = !reset && (bus.tx_valid === 1'b1) && !rdy;
    prev_dat   = bus.tx_dat;
    prev_sof   = bus.tx_sof;
    prev_eof   = bus.tx_eof;
    if (!reset && bus.en_fiforead === 1'b1) begin
      if (bus.compfifo_dav !== 1'b1) pop_empty_err++;
      else begin
        pop_pending = 1'b1;
        pops++;
      end
    end
    if (!reset && bus.tx_valid === 1'b1 && rdy) begin
      cap_dat.push_back(bus.tx_dat);
      cap_sof.push_back(bus.tx_sof);
      cap_eof.push_back(bus.tx_eof);
      cap_cyc.push_back(cyc);
      if (bus.tx_eof === 1'b1) n_eof++;
    end
  endtask

  // Reference packet: consumes up to NTW words the FIFO holds, zero-fills the rest.
  function automatic void build_pkt(input logic [15:0] seq);
    int          n;
    logic        uf;
    logic [47:0] w;
    n  = (model_words.size() < NTW) ? model_words.size() : NTW;
    uf = (n < NTW);
    for (int i = 0; i < NPRE; i++) exp_q.push_back(16'h0000);
    exp_q.push_back({8'hCF, 8'(FIBER)});
    exp_q.push_back(seq);
    for (int i = 0; i < NTW; i++) begin
      if (i < n) w = model_words.pop_front();
      else w = 48'h0;
      exp_q.push_back(w[47:32]);
      exp_q.push_back(w[31:16]);
      exp_q.push_back(w[15:0]);
    end
    exp_q.push_back({8'hCE, 7'b0, uf});
  endfunction

  function automatic void clear_capture();
    cap_dat.delete();
    cap_sof.delete();
    cap_eof.delete();
    cap_cyc.delete();
    exp_q.delete();
    n_eof     = 0;
    pops      = 0;
    stall_err = 0;
  endfunction

  function automatic void push_word(input logic [47:0] w);
    fifo_q.push_back(w);
    model_words.push_back(w);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1);
    step(1'b1);
    tests_run++;
    if ({bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.en_fiforead, bus.busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, expected 00000",
               {bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.en_fiforead, bus.busy});
    end
    tests_run++;
    if (bus.tx_dat !== 16'h0 || bus.pkt_count !== 16'h0 || bus.underrun_count !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_data: dat=%h pkt=%h und=%h, expected all 0",
               bus.tx_dat, bus.pkt_count, bus.underrun_count);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_empty: busy=%b valid=%b, expected 0 0", bus.busy, bus.tx_valid);
    end
  endtask

  task automatic test_reset_mid();
    clear_capture();
    for (int i = 0; i < NTW; i++) push_word({16'($urandom()), $urandom()});
    for (int k = 0; k < 200 && cap_dat.size() < NPRE + 2 + 10; k++) step(1'b1);
    tests_run++;
    if (cap_dat.size() != NPRE + 2 + 10) begin
      tests_failed++;
      $display("FAIL mid_reach: got %0d words, expected %0d", cap_dat.size(), NPRE + 12);
    end
    reset = 1'b1;
    fifo_q.delete();
    model_words.delete();
    pop_pending = 1'b0;
    step(1'b1);
    reset = 1'b0;
    step(1'b1);
    tests_run++;
    if ({bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.en_fiforead, bus.busy} !== 5'b0 ||
        bus.tx_dat !== 16'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_out: ctrl=%b dat=%h, expected 00000 0000",
               {bus.tx_valid, bus.tx_sof, bus.tx_eof, bus.en_fiforead, bus.busy}, bus.tx_dat);
    end
    tests_run++;
    if (bus.pkt_count !== exp_pkt) begin
      tests_failed++;
      $display("FAIL mid_reset_pkt: got %h, expected %h", bus.pkt_count, exp_pkt);
    end
    for (int k = 0; k < 5; k++) step(1'b1);
    tests_run++;
    if (cap_dat.size() != NPRE + 12 || n_eof != 0) begin
      tests_failed++;
      $display("FAIL mid_no_trailer: words=%0d eofs=%0d, expected %0d 0",
               cap_dat.size(), n_eof, NPRE + 12);
    end
  endtask

  task automatic test_basic();
    int sofs;
    clear_capture();
    for (int i = 0; i < NTW; i++) push_word(48'h0123_4567_89AB + 48'(i));
    build_pkt(exp_pkt);
    step(1'b1);
    tests_run++;
    if (bus.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_start: valid=%b, expected 0", bus.tx_valid);
    end
    step(1'b1);
    tests_run++;
    if (bus.tx_valid !== 1'b1 || bus.tx_sof !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_latency: valid=%b sof=%b, expected 1 1", bus.tx_valid, bus.tx_sof);
    end
    for (int k = 0; k < 300 && n_eof < 1; k++) step(1'b1);
    step(1'b1);
    exp_pkt++;
    tests_run++;
    if (cap_dat.size() != PKT_LEN) begin
      tests_failed++;
      $display("FAIL basic_len: got %0d, expected %0d", cap_dat.size(), PKT_LEN);
    end
    for (int i = 0; i < exp_q.size() && i < cap_dat.size(); i++) begin
      tests_run++;
      if (cap_dat[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL basic_word[%0d]: got %h, expected %h", i, cap_dat[i], exp_q[i]);
      end
    end
    tests_run++;
    if (cap_dat[NPRE] !== 16'hCF03 || cap_dat[NPRE+1] !== 16'h0000 ||
        cap_dat[NPRE+2] !== 16'h0123 || cap_dat[PKT_LEN-1] !== 16'hCE00) begin
      tests_failed++;
      $display("FAIL basic_fields: hdr=%h seq=%h d0=%h trl=%h, expected cf03 0000 0123 ce00",
               cap_dat[NPRE], cap_dat[NPRE+1], cap_dat[NPRE+2], cap_dat[PKT_LEN-1]);
    end
    sofs = 0;
    foreach (cap_sof[i]) if (cap_sof[i]) sofs++;
    tests_run++;
    if (sofs != 1 || cap_sof[0] !== 1'b1 || cap_eof[PKT_LEN-1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_framing: sofs=%0d sof0=%b eof_last=%b, expected 1 1 1",
               sofs, cap_sof[0], cap_eof[PKT_LEN-1]);
    end
    tests_run++;
    if (bus.pkt_count !== exp_pkt || pops != NTW || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after: pkt=%h pops=%0d busy=%b, expected %h %0d 0",
               bus.pkt_count, pops, bus.busy, exp_pkt, NTW);
    end
  endtask

  task automatic test_backpressure();
    clear_capture();
    for (int i = 0; i < NTW; i++) push_word({16'($urandom()), $urandom()});
    build_pkt(exp_pkt);
    for (int k = 0; k < 400 && n_eof < 1; k++) step(1'(k));
    exp_pkt++;
    for (int k = 0; k < 3; k++) step(1'b0);
    for (int i = 0; i < NTW; i++) push_word({16'($urandom()), $urandom()});
    build_pkt(exp_pkt);
    for (int k = 0; k < 800 && n_eof < 2; k++) step(1'($urandom_range(0, 1)));
    for (int k = 0; k < 2; k++) step(1'b0);
    exp_pkt++;
    tests_run++;
    if (cap_dat.size() != 2 * PKT_LEN) begin
      tests_failed++;
      $display("FAIL bp_len: got %0d, expected %0d", cap_dat.size(), 2 * PKT_LEN);
    end
    for (int i = 0; i < exp_q.size() && i < cap_dat.size(); i++) begin
      tests_run++;
      if (cap_dat[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL bp_word[%0d]: got %h, expected %h", i, cap_dat[i], exp_q[i]);
      end
    end
    tests_run++;
    if (stall_err != 0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d unstable stalls, expected 0", stall_err);
    end
    tests_run++;
    if (bus.pkt_count !== exp_pkt || pops != 2 * NTW) begin
      tests_failed++;
      $display("FAIL bp_after: pkt=%h pops=%0d, expected %h %0d",
               bus.pkt_count, pops, exp_pkt, 2 * NTW);
    end
  endtask

  task automatic test_underrun();
    clear_capture();
    for (int i = 0; i < 5; i++) push_word({16'($urandom()), $urandom()});
    build_pkt(exp_pkt);
    for (int k = 0; k < 1500 && n_eof < 1; k++) step(1'b1);
    for (int k = 0; k < 2; k++) step(1'b1);
    exp_pkt++;
    exp_under++;
    tests_run++;
    if (cap_dat.size() != PKT_LEN) begin
      tests_failed++;
      $display("FAIL ur_len: got %0d, expected %0d", cap_dat.size(), PKT_LEN);
    end
    for (int i = 0; i < exp_q.size() && i < cap_dat.size(); i++) begin
      tests_run++;
      if (cap_dat[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL ur_word[%0d]: got %h, expected %h", i, cap_dat[i], exp_q[i]);
      end
    end
    tests_run++;
    if (cap_dat[PKT_LEN-1] !== 16'hCE01) begin
      tests_failed++;
      $display("FAIL ur_trailer: got %h, expected ce01", cap_dat[PKT_LEN-1]);
    end
    tests_run++;
    if (bus.underrun_count !== exp_under || pops != 5 || bus.pkt_count !== exp_pkt) begin
      tests_failed++;
      $display("FAIL ur_after: und=%h pops=%0d pkt=%h, expected %h 5 %h",
               bus.underrun_count, pops, bus.pkt_count, exp_under, exp_pkt);
    end
  endtask

  task automatic test_back_to_back();
    clear_capture();
    for (int i = 0; i < 2 * NTW; i++) push_word({16'($urandom()), $urandom()});
    build_pkt(exp_pkt);
    build_pkt(exp_pkt + 16'd1);
    for (int k = 0; k < 400 && n_eof < 2; k++) step(1'b1);
    step(1'b1);
    exp_pkt += 16'd2;
    tests_run++;
    if (cap_dat.size() != 2 * PKT_LEN) begin
      tests_failed++;
      $display("FAIL b2b_len: got %0d, expected %0d", cap_dat.size(), 2 * PKT_LEN);
    end
    for (int i = 0; i < exp_q.size() && i < cap_dat.size(); i++) begin
      tests_run++;
      if (cap_dat[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL b2b_word[%0d]: got %h, expected %h", i, cap_dat[i], exp_q[i]);
      end
    end
    tests_run++;
    if (cap_eof[PKT_LEN-1] !== 1'b1 || cap_sof[PKT_LEN] !== 1'b1 ||
        cap_cyc[PKT_LEN] - cap_cyc[PKT_LEN-1] != 2) begin
      tests_failed++;
      $display("FAIL b2b_gap: eof=%b sof=%b gap=%0d cycles, expected 1 1 2",
               cap_eof[PKT_LEN-1], cap_sof[PKT_LEN], cap_cyc[PKT_LEN] - cap_cyc[PKT_LEN-1]);
    end
    tests_run++;
    if (bus.pkt_count !== exp_pkt) begin
      tests_failed++;
      $display("FAIL b2b_pkt: got %h, expected %h", bus.pkt_count, exp_pkt);
    end
  endtask

  task automatic test_wrap();
    clear_capture();
    force dut.pkt_count_q = 16'hFFFF;
    step(1'b1);
    release dut.pkt_count_q;
    step(1'b1);
    exp_pkt = 16'hFFFF;
    for (int i = 0; i < 2 * NTW; i++) push_word({16'($urandom()), $urandom()});
    build_pkt(exp_pkt);
    build_pkt(exp_pkt + 16'd1);
    for (int k = 0; k < 400 && n_eof < 2; k++) step(1'b1);
    step(1'b1);
    exp_pkt += 16'd2;
    tests_run++;
    if (cap_dat[NPRE+1] !== 16'hFFFF || cap_dat[PKT_LEN+NPRE+1] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_seq: got %h %h, expected ffff 0000",
               cap_dat[NPRE+1], cap_dat[PKT_LEN+NPRE+1]);
    end
    for (int i = 0; i < exp_q.size() && i < cap_dat.size(); i++) begin
      tests_run++;
      if (cap_dat[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL wrap_word[%0d]: got %h, expected %h", i, cap_dat[i], exp_q[i]);
      end
    end
    tests_run++;
    if (bus.pkt_count !== exp_pkt) begin
      tests_failed++;
      $display("FAIL wrap_pkt: got %h, expected %h", bus.pkt_count, exp_pkt);
    end
  endtask

  initial begin
    bus.compfifo_dav  = 1'b0;
    bus.compfifo_dout = '0;
    bus.tx_ready      = 1'b0;
    test_reset();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_underrun();
    test_back_to_back();
    test_wrap();
    tests_run++;
    if (pop_empty_err != 0) begin
      tests_failed++;
      $display("FAIL pop_when_empty: got %0d, expected 0", pop_empty_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
